// File: rtl/mavg_pkg.sv
// Shared types, defaults and window helper for the moving-average sequencer.
// The MAVG_SEQ_WARMUP_EN build macro enables the FILL stage in the sequencer.
package mavg_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

  localparam int DATA_IN_LEN_DEFAULT = 10;
  localparam int FILL_CNT_W          = 5;

  localparam logic [1:0] SEL_TAPS_2  = 2'b00;
  localparam logic [1:0] SEL_TAPS_4  = 2'b01;
  localparam logic [1:0] SEL_TAPS_8  = 2'b10;
  localparam logic [1:0] SEL_TAPS_16 = 2'b11;

  // Window length for a width code: 2^(code+1) taps.
  function automatic logic [FILL_CNT_W-1:0] window_len(input logic [1:0] code);
    return 5'd2 << code;
  endfunction

endpackage

// File: rtl/mavg_fill_counter.sv
// Counts results returned since the last filter clear; done flags the result
// that completes the window. Only instantiated when MAVG_SEQ_WARMUP_EN is defined.
module mavg_fill_counter
  import mavg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  input  logic [FILL_CNT_W-1:0] target,
  output logic                  done
);

  logic [FILL_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 5'd1;
    end
  end

  assign done = inc && ((count + 5'd1) == target);

endmodule

// File: rtl/moving_average_sequencer.sv
// Paces samples into the moving-average filter bank, one in flight at a time.
// Define MAVG_SEQ_WARMUP_EN to suppress partial-window results after each clear.
module moving_average_sequencer
  import mavg_pkg::*;
#(
  parameter int DATA_IN_LEN = DATA_IN_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_IN_LEN-1:0] s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [1:0]             sel_req_i,
  input  logic                   sel_load_i,
  output logic [DATA_IN_LEN-1:0] flt_data_o,
  output logic                   flt_strobe_o,
  output logic [1:0]             flt_sel_o,
  output logic                   flt_clear_o,
  input  logic [DATA_IN_LEN-1:0] flt_data_i,
  input  logic                   flt_strobe_i,
  output logic [DATA_IN_LEN-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   busy_o
);

  seq_state_t state;
  logic       pending;
  logic       change_pending;
  logic [1:0] sel_next;
  logic       accept;
  logic       result_in;
  logic       apply_change;

  assign s_ready_o    = (state != CLEAR) && !pending && !change_pending &&
                        !(m_valid_o && !m_ready_i);
  assign accept       = s_valid_i && s_ready_o;
  assign result_in    = flt_strobe_i && pending;
  assign apply_change = change_pending && !pending;

  // flt_clear_o stands in for the CLEAR state so busy_o stays low under reset.
  assign busy_o = flt_clear_o || (state == FILL) || change_pending;

`ifdef MAVG_SEQ_WARMUP_EN
  logic fill_done;

  mavg_fill_counter u_fill_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == CLEAR),
    .inc    (result_in && (state == FILL)),
    .target (window_len(flt_sel_o)),
    .done   (fill_done)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= CLEAR;
      pending        <= 1'b0;
      change_pending <= 1'b0;
      sel_next       <= SEL_TAPS_2;
      flt_data_o     <= '0;
      flt_strobe_o   <= 1'b0;
      flt_sel_o      <= SEL_TAPS_2;
      flt_clear_o    <= 1'b0;
      m_data_o       <= '0;
      m_valid_o      <= 1'b0;
    end else begin
      flt_strobe_o <= 1'b0;
      if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
      end
      if (accept) begin
        flt_data_o   <= s_data_i;
        flt_strobe_o <= 1'b1;
        pending      <= 1'b1;
      end

      case (state)
        CLEAR: begin
          // Right after reset the pulse is raised here; a width change enters with it already high.
          flt_clear_o <= !flt_clear_o;
          if (flt_clear_o) begin
`ifdef MAVG_SEQ_WARMUP_EN
            state <= FILL;
`else
            state <= RUN;
`endif
          end
        end
`ifdef MAVG_SEQ_WARMUP_EN
        FILL: begin
          if (result_in) begin
            pending <= 1'b0;
            if (fill_done) begin
              m_data_o  <= flt_data_i;
              m_valid_o <= 1'b1;
              state     <= RUN;
            end
          end
        end
`endif
        RUN: begin
          if (result_in) begin
            pending   <= 1'b0;
            m_data_o  <= flt_data_i;
            m_valid_o <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase

      if (apply_change) begin
        flt_sel_o      <= sel_next;
        change_pending <= 1'b0;
        flt_clear_o    <= 1'b1;
        state          <= CLEAR;
      end
      // A load in the same cycle as an apply starts a fresh pending change.
      if (sel_load_i) begin
        change_pending <= 1'b1;
        sel_next       <= sel_req_i;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Self-checking bench for moving_average_sequencer; the bench plays the filter bank.
// Expected forwarding follows MAVG_SEQ_WARMUP_EN when the build defines it.
module tb_moving_average_sequencer;

  localparam int DW = 10;

`ifdef MAVG_SEQ_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    sel_req = 2'b00;
  logic          sel_load = 1'b0;
  logic [DW-1:0] flt_data_out;
  logic          flt_strobe_out;
  logic [1:0]    flt_sel;
  logic          flt_clear;
  logic [DW-1:0] flt_data_in = '0;
  logic          flt_strobe_in = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          busy;

  always #5 clk = ~clk;

  moving_average_sequencer #(.DATA_IN_LEN(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .sel_req_i    (sel_req),
    .sel_load_i   (sel_load),
    .flt_data_o   (flt_data_out),
    .flt_strobe_o (flt_strobe_out),
    .flt_sel_o    (flt_sel),
    .flt_clear_o  (flt_clear),
    .flt_data_i   (flt_data_in),
    .flt_strobe_i (flt_strobe_in),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .busy_o       (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: results counted per width epoch, forwarded once the window is full.
  int            outstanding = 0;
  int            ret_cd = 0;
  int            mdl_code = 0;
  int            mdl_next = 0;
  bit            mdl_change = 1'b0;
  int            mdl_cnt = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_count = 0;
  int            hs_count = 0;
  int            clear_pulses = 0;
  bit            fixed_mode = 1'b1;
  bit            rand_delay = 1'b0;
  bit            stray_en = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: sample just before the edge, then update model and responder after it.
  task automatic applyStimulus();
    bit            acc, ld, hs, held, ret;
    logic [1:0]    ld_code;
    logic [DW-1:0] acc_data, ret_val, prev_mdata;
    #2;
    acc        = s_valid && s_ready;
    acc_data   = s_data;
    ld         = sel_load;
    ld_code    = sel_req;
    hs         = m_valid && m_ready;
    held       = m_valid && !m_ready;
    prev_mdata = m_data;
    ret        = flt_strobe_in;
    ret_val    = flt_data_in;
    if (outstanding != 0 || held) checkOutput("s_ready_gated", s_ready, 0);
    if (hs) begin
      hs_count++;
      checkOutput("m_result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        checkOutput("m_data", m_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    sel_load      = 1'b0;
    flt_strobe_in = 1'b0;
    if (flt_clear) clear_pulses++;
    if (ret && outstanding != 0) begin
      outstanding = 0;
      mdl_cnt++;
      if (!WARM || mdl_cnt >= (1 << (mdl_code + 1))) exp_q.push_back(ret_val);
    end
    checkOutput("flt_strobe", flt_strobe_out, acc);
    if (acc) begin
      acc_count++;
      checkOutput("flt_data", flt_data_out, acc_data);
      if (mdl_change) begin
        mdl_code   = mdl_next;
        mdl_cnt    = 0;
        mdl_change = 1'b0;
      end
      outstanding = 1;
      ret_cd      = rand_delay ? int'($urandom_range(0, 3)) : 2;
    end
    if (ld) begin
      mdl_change = 1'b1;
      mdl_next   = int'(ld_code);
    end
    if (held) begin
      checkOutput("m_valid_hold", m_valid, 1);
      checkOutput("m_data_hold", m_data, prev_mdata);
    end
    if (outstanding != 0) begin
      if (ret_cd == 0) begin
        flt_strobe_in = 1'b1;
        flt_data_in   = fixed_mode ? 10'h100 : 10'($urandom);
      end else begin
        ret_cd--;
      end
    end else if (stray_en && ($urandom % 8 == 0)) begin
      flt_strobe_in = 1'b1;
      flt_data_in   = 10'($urandom);
    end
  endtask

  task automatic pulseReset();
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_flt_sel", flt_sel, 0);
    checkOutput("rst_flt_strobe", flt_strobe_out, 0);
    checkOutput("rst_flt_clear", flt_clear, 0);
    checkOutput("rst_flt_data", flt_data_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    outstanding = 0;
    ret_cd      = 0;
    mdl_code    = 0;
    mdl_cnt     = 0;
    mdl_change  = 1'b0;
    exp_q.delete();
    flt_strobe_in = 1'b0;
    s_valid       = 1'b0;
    sel_load      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkClearAfterReset();
    int c0;
    c0 = clear_pulses;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("clear_once_after_reset", clear_pulses - c0, 1);
  endtask

  task automatic feedSamples(input int n);
    int target;
    target  = acc_count + n;
    s_valid = 1'b1;
    for (int i = 0; i < 50 * n && acc_count < target; i++) begin
      s_data = fixed_mode ? 10'h100 : 10'($urandom);
      applyStimulus();
    end
    s_valid = 1'b0;
    checkOutput("feed_complete", acc_count, target);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 300 && (outstanding != 0 || exp_q.size() != 0 || m_valid); i++)
      applyStimulus();
    checkOutput("drain_done", (outstanding == 0) && (exp_q.size() == 0) && !m_valid, 1);
  endtask

  initial begin
    int h0, c0;
    @(posedge clk);
    #1;
    pulseReset();
    checkClearAfterReset();

    // Warm-up at the default width of 2 taps.
    fixed_mode = 1'b1;
    h0 = hs_count;
    feedSamples(4);
    drain();
    checkOutput("warmup_forwarded", hs_count - h0, WARM ? 3 : 4);
    checkOutput("idle_busy", busy, 0);

    // Width change requested one cycle after an acceptance.
    fixed_mode = 1'b0;
    feedSamples(1);
    h0 = hs_count;
    sel_req  = 2'b11;
    sel_load = 1'b1;
    applyStimulus();
    for (int i = 0; i < 20 && outstanding != 0; i++) begin
      checkOutput("sel_held_in_flight", flt_sel, 0);
      checkOutput("busy_change_pending", busy, 1);
      applyStimulus();
    end
    c0 = clear_pulses;
    for (int i = 0; i < 5 && flt_sel != 2'b11; i++) applyStimulus();
    checkOutput("sel_after_return", flt_sel, 3);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("clear_once_after_change", clear_pulses - c0, 1);
    feedSamples(16);
    drain();
    checkOutput("forwarded_after_change", hs_count - h0, WARM ? 2 : 17);

    // Backpressure holds the output and blocks new samples.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 200 && !m_valid; i++) begin
      s_data = 10'($urandom);
      applyStimulus();
    end
    checkOutput("bp_valid_seen", m_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_s_ready", s_ready, 0);
      applyStimulus();
    end
    drain();

    // Asynchronous reset with a sample in flight.
    feedSamples(1);
    pulseReset();
    checkClearAfterReset();

    // Stray filter strobe with nothing outstanding, during warm-up.
    flt_data_in   = 10'h2AA;
    flt_strobe_in = 1'b1;
    applyStimulus();
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("stray_no_valid", m_valid, 0);
    fixed_mode = 1'b1;
    h0 = hs_count;
    feedSamples(2);
    drain();
    checkOutput("stray_not_counted", hs_count - h0, WARM ? 1 : 2);

    // Randomized traffic with width changes, backpressure and stray strobes.
    fixed_mode = 1'b0;
    rand_delay = 1'b1;
    stray_en   = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      s_valid = 1'($urandom % 2);
      s_data  = 10'($urandom);
      m_ready = ($urandom % 10) < 7;
      if ($urandom % 32 == 0) begin
        sel_load = 1'b1;
        sel_req  = 2'($urandom);
      end
      applyStimulus();
    end
    stray_en = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_average_sequencer.md
# moving_average_sequencer

Sequencer that sits between the sample source and the moving-average filter bank. It paces samples into the filter with single-cycle strobes and keeps at most one sample in flight. It changes filter width only when no sample is outstanding, clears the filter history on every width change, and suppresses warm-up results until the window is full. Forwarded results go out on a valid/ready port.

## Interface
- `DATA_IN_LEN`, default 10: sample and result width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs return to reset values immediately.
- `s_data_i` in DATA_IN_LEN: input sample.
- `s_valid_i` in 1: sample offered.
- `s_ready_o` out 1: sample accepted on a cycle where `s_valid_i && s_ready_o`.
- `sel_req_i` in 2: requested width code. 00→2, 01→4, 10→8, 11→16 taps. N = 2^(code+1).
- `sel_load_i` in 1: single-cycle pulse; latch `sel_req_i` as a pending width change.
- `flt_data_o` out DATA_IN_LEN: sample to filter bank.
- `flt_strobe_o` out 1: one-cycle sample strobe to filter bank.
- `flt_sel_o` out 2: active width code to filter bank output mux.
- `flt_clear_o` out 1: one-cycle filter-history clear.
- `flt_data_i` in DATA_IN_LEN: filter result.
- `flt_strobe_i` in 1: filter result valid, one cycle.
- `m_data_o` out DATA_IN_LEN: forwarded result.
- `m_valid_o` out 1: result held until `m_ready_i`.
- `m_ready_i` in 1: downstream accepts.
- `busy_o` out 1: high in CLEAR/FILL or while a change is pending.

## Operation
- Reset values:
  - all outputs 0 (`flt_sel_o`=00);
  - state CLEAR;
  - pending=0, change_pending=0, fill_cnt=0.
- States:
  - CLEAR: `flt_clear_o`=1 for exactly one cycle, fill_cnt←0. Next state is FILL, or RUN if the FILL stage is compiled out (see Configuration).
  - FILL: samples accepted. On each `flt_strobe_i` while pending: fill_cnt++, and pending←0.
    - If the new fill_cnt == N, forward the result and go to RUN.
    - Otherwise discard the result.
  - RUN: every `flt_strobe_i` while pending is forwarded, and pending←0.
- `s_ready_o` = state∈{FILL,RUN} && !pending && !change_pending && !(m_valid_o && !m_ready_i). Combinational from registers only.
- Sample acceptance: flt_data_o←s_data_i, flt_strobe_o pulse, pending←1.
- `flt_strobe_i` while !pending is ignored, with no state change. This includes strobes seen in CLEAR.
- Width change:
  - `sel_load_i` sets change_pending and latches sel_next←`sel_req_i`.
  - A second load before the change is applied overwrites sel_next.
  - The change applies on the first cycle with change_pending && !pending: flt_sel_o←sel_next, change_pending←0, go to CLEAR.
- `sel_load_i` on the same cycle as a sample acceptance: the sample is processed under the old width, and the change applies after its result returns.
- A result already held in `m_valid_o` when a change applies stays held until accepted.
- `sel_load_i` during CLEAR or FILL is legal and restarts the sequence via CLEAR once !pending.
- Output register:
  - `m_valid_o` set on forward;
  - cleared on `m_valid_o && m_ready_i`;
  - at most one entry, which acceptance gating guarantees.

## Timing
- Acceptance at edge t: `flt_strobe_o`=1 and `flt_data_o` valid during cycle t+1 only.
- `flt_strobe_i` at edge r (while pending): `m_valid_o`=1 and `m_data_o`=`flt_data_i`@r from cycle r+1.
  - `s_ready_o` can reassert in cycle r+1 if the output slot is free.
- Width change applied at edge c: `flt_sel_o` new value and `flt_clear_o`=1 in cycle c+1; state FILL from cycle c+2.
- First forwarded result after a clear is the Nth returned result.
- Reset asserted mid-transfer: pending result is lost, output is dropped, and the sequence restarts with a CLEAR.

## Configuration
- `MAVG_SEQ_WARMUP_EN` defined: FILL state and fill counter present; the first N−1 results after each clear are discarded.
- Undefined: no FILL and no counter. CLEAR goes directly to RUN, and every result after the clear is forwarded, including partial-window ones.

## Structure
- Shared package `mavg_pkg`:
  - state enum {CLEAR, FILL, RUN};
  - DATA_IN_LEN default;
  - width-code localparams;
  - function `window_len(code)` returning 2^(code+1).
- One natural sub-module, `mavg_fill_counter`, compiled only under `MAVG_SEQ_WARMUP_EN`:
  - inputs clear, inc, target N;
  - output done.

## Test plan
- Warm-up, default width: reset, then feed 4 samples of 0x100, each returned 2 cycles later as 0x100 → first `m_valid_o` only after the 2nd result; exactly 3 forwarded results, all 0x100.
- Width change mid-flight: `sel_load_i` with code 11 one cycle after acceptance → `flt_sel_o` holds 00 until the result returns, then becomes 11. `flt_clear_o` pulses once, and the next 15 results are discarded.
- Backpressure: `m_ready_i`=0 with `m_valid_o` held → `s_ready_o`=0, no `flt_strobe_o`, and `m_data_o` stable until `m_ready_i`=1.
- Stray strobe: `flt_strobe_i` with no sample outstanding → no `m_valid_o`, fill_cnt unchanged.
- Async reset in RUN with pending=1 → all outputs 0 immediately, and `flt_clear_o` pulses in the first cycle after deassertion.
- Build without `MAVG_SEQ_WARMUP_EN`, code 01, 4 samples → 4 results forwarded, including the first.
